uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 12 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 80 ++++++++
 tb/tb_uart_tx_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: default depth and sequencer states.
package uart_tx_fifo_pkg;

  localparam int unsigned DefaultDepth = 16;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StWaitStart = 2'b01,
    StWaitDone  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte buffer with registered count/flags and a one-cycle overflow pulse.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q;
  logic             accept, pop_ok;

  assign full   = (count_q == CntW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign overflow = overflow_q;
  assign head   = mem[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop_ok = pop && !empty;
  assign accept = push && (!full || pop_ok);

  always_comb begin
    count_d = count_q;
    unique case ({accept, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= push && !accept;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define what is held.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a uart_tx: pops one byte per frame and sequences its start/done handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst,
  input  logic                   i_Wr_DV,
  input  logic [7:0]             i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Overflow,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done
);

  seq_state_e state_q, state_d;
  logic       done_prev_q;
  logic [7:0] tx_byte_q;
  logic [7:0] head;
  logic       pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (i_Clock),
    .rst       (i_Rst),
    .push      (i_Wr_DV),
    .push_data (i_Wr_Byte),
    .pop       (pop),
    .head      (head),
    .full      (o_Full),
    .empty     (o_Empty),
    .count     (o_Count),
    .overflow  (o_Overflow)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!o_Empty) begin
          pop     = 1'b1;
          state_d = StWaitStart;
        end
      end
      StWaitStart: begin
        if (i_TX_Active) state_d = StWaitDone;
      end
      StWaitDone: begin
        // Only a fresh Done edge ends the frame; a lingering level is ignored.
        if (i_TX_Done && !done_prev_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The strobe coincides with the pop, so a full FIFO can accept a write on the strobe cycle.
  assign o_TX_DV   = pop;
  assign o_TX_Byte = pop ? head : tx_byte_q;

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= StIdle;
      done_prev_q <= 1'b0;
      tx_byte_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      done_prev_q <= i_TX_Done;
      if (pop) tx_byte_q <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural uart_tx (serial frame + loopback receiver).
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CLKS_PER_BIT = 4;

  logic       clk, rst;
  logic       wr_dv;
  logic [7:0] wr_byte;
  logic       full, empty, overflow, tx_dv, tx_active, tx_done;
  logic [2:0] count;
  logic [7:0] tx_byte;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock     (clk),
    .i_Rst       (rst),
    .i_Wr_DV     (wr_dv),
    .i_Wr_Byte   (wr_byte),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
    .o_Overflow  (overflow),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .i_TX_Active (tx_active),
    .i_TX_Done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural uart_tx: 10-bit frame, Done held for done_len cycles.
  int unsigned done_len = 1;
  logic        busy;
  int unsigned bit_clks, done_left;
  logic [7:0]  cur;
  logic [9:0]  frame, rx_sh;
  logic        serial;
  logic [7:0]  rx[$];
  int unsigned dv_seen = 0, dv_busy_err = 0, byte_err = 0;

  assign frame  = {1'b1, cur, 1'b0};
  assign serial = busy ? frame[bit_clks / CLKS_PER_BIT] : 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; tx_active <= 1'b0; tx_done <= 1'b0;
      done_left <= 0; bit_clks <= 0; cur <= 8'h00; rx_sh <= '0;
    end else begin
      if (done_left > 0) begin
        if (done_left == 1) tx_done <= 1'b0;
        done_left <= done_left - 1;
      end
      if (!busy) begin
        if (tx_dv) begin
          busy <= 1'b1; tx_active <= 1'b1; cur <= tx_byte; bit_clks <= 0;
          dv_seen <= dv_seen + 1;
        end
      end else begin
        if (tx_dv) dv_busy_err <= dv_busy_err + 1;
        if (tx_byte != cur) byte_err <= byte_err + 1;
        if (bit_clks % CLKS_PER_BIT == CLKS_PER_BIT / 2) rx_sh <= {serial, rx_sh[9:1]};
        if (bit_clks == 10 * CLKS_PER_BIT - 1) begin
          busy <= 1'b0; tx_active <= 1'b0; tx_done <= 1'b1; done_left <= done_len;
          rx.push_back(rx_sh[8:1]);
        end else begin
          bit_clks <= bit_clks + 1;
        end
      end
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_dv = 1'b1; wr_byte = b;
    step();
    wr_dv = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 2000 && rx.size() < n; i++) step();
    check("rx_count", rx.size(), n);
  endtask

  task automatic wait_dv(input string tag);
    int i;
    for (i = 0; i < 200 && !tx_dv; i++) step();
    check(tag, tx_dv, 1'b1);
  endtask

  int base, dv0;
  logic [7:0] exp_b [6];

  initial begin
    rst = 1'b1; wr_dv = 1'b0; wr_byte = 8'h00;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_dv", tx_dv, 1'b0);
    check("rst_byte", tx_byte, 8'h00);

    // Single byte: strobe in the cycle right after the write edge.
    base = rx.size();
    wr(8'hA5);
    check("single_dv", tx_dv, 1'b1);
    check("single_byte", tx_byte, 8'hA5);
    check("single_cnt", count, 3'd1);
    step();
    check("single_dv_low", tx_dv, 1'b0);
    check("single_empty", empty, 1'b1);
    wait_rx(base + 1);
    if (rx.size() > base) check("single_rx", rx[base], 8'hA5);
    repeat (5) step();

    // Burst behind a priming byte, then overflow and full-with-pop.
    base = rx.size();
    wr(8'h00);
    repeat (2) step();
    for (int k = 1; k <= 4; k++) wr(8'(k));
    check("burst_full", full, 1'b1);
    check("burst_cnt", count, 3'd4);
    wr(8'hFF);
    check("ovf_pulse", overflow, 1'b1);
    check("ovf_cnt", count, 3'd4);
    step();
    check("ovf_clear", overflow, 1'b0);
    wait_dv("fullpop_dv");
    check("fullpop_byte", tx_byte, 8'h01);
    check("fullpop_full", full, 1'b1);
    wr(8'h05);
    check("fullpop_cnt", count, 3'd4);
    check("fullpop_ovf", overflow, 1'b0);
    wait_rx(base + 6);
    for (int k = 0; k < 6; k++) exp_b[k] = 8'(k);
    for (int k = 0; k < 6; k++)
      if (rx.size() > base + k) check("burst_order", rx[base + k], exp_b[k]);
    repeat (50) step();

    // Long Done levels must not retrigger the sequencer.
    for (int d = 0; d < 2; d++) begin
      done_len = (d == 0) ? 2 : 4;
      base = rx.size();
      dv0 = dv_seen;
      wr(8'h11); wr(8'h22); wr(8'h33);
      wait_rx(base + 3);
      repeat (60) step();
      check("longdone_dvs", dv_seen - dv0, 3);
      if (rx.size() >= base + 3) begin
        check("longdone_b0", rx[base], 8'h11);
        check("longdone_b1", rx[base + 1], 8'h22);
        check("longdone_b2", rx[base + 2], 8'h33);
      end
    end
    done_len = 1;
    check("dv_while_busy", dv_busy_err, 0);
    check("byte_unstable", byte_err, 0);

    // Asynchronous reset between edges mid-burst.
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    repeat (5) step();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_empty", empty, 1'b1);
    check("arst_full", full, 1'b0);
    check("arst_cnt", count, 3'd0);
    check("arst_dv", tx_dv, 1'b0);
    check("arst_byte", tx_byte, 8'h00);
    check("arst_ovf", overflow, 1'b0);
    step();
    rst = 1'b0;
    dv0 = dv_seen;
    repeat (60) step();
    check("arst_no_dv", dv_seen - dv0, 0);
    base = rx.size();
    wr(8'hB7);
    wait_rx(base + 1);
    if (rx.size() > base) check("arst_after", rx[base], 8'hB7);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
